// File: rtl/color_map2d_stream_if.sv
// Stream bundle for color_map2d_stream.
// Purpose: groups the input beat (x, y, mode, in_last with valid/ready) and
// the output beat (r, g, b, out_last with valid/ready) into one interface.
// Modports:
//   master - the producer/consumer side (drives the input beat and out_ready)
//   slave  - the colour mapper (accepts input beats, produces output beats)
interface color_map2d_stream_if #(
  parameter int W  = 8,
  parameter int OW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [1:0]    mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] r;
  logic [OW-1:0] g;
  logic [OW-1:0] b;
  logic          out_last;

  modport master (
    output in_valid, x, y, mode, in_last, out_ready,
    input  in_ready, out_valid, r, g, b, out_last
  );

  modport slave (
    input  in_valid, x, y, mode, in_last, out_ready,
    output in_ready, out_valid, r, g, b, out_last
  );
endinterface

// File: rtl/color_map2d_stream.sv
// color_map2d_stream: maps a coordinate pair (x, y) to an RGB colour using
// one of four colour maps chosen per beat by mode. Two-stage valid/ready
// pipeline: S1 captures the beat, S2 holds the computed colour.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   s   - stream bundle (slave side): in_valid/in_ready/x/y/mode/in_last in,
//         out_valid/out_ready/r/g/b/out_last out
module color_map2d_stream #(
  parameter int W  = 8,
  parameter int OW = 8
) (
  input logic                clk,
  input logic                rst,
  color_map2d_stream_if.slave s
);

  logic          s1_valid;
  logic          s2_valid;
  logic          adv1;
  logic          adv2;

  logic [W-1:0]  s1_x_reg;
  logic [W-1:0]  s1_y_reg;
  logic [1:0]    s1_mode_reg;
  logic          s1_last_reg;

  logic [OW-1:0] r_reg;
  logic [OW-1:0] g_reg;
  logic [OW-1:0] b_reg;
  logic          last_reg;

  logic [OW-1:0] r_next;
  logic [OW-1:0] g_next;
  logic [OW-1:0] b_next;

  logic [W:0]    sum;
  logic [W-1:0]  d;
  logic [OW-1:0] avg;
  logic [OW-1:0] dv;
  logic [OW-1:0] xt;
  logic [OW-1:0] yt;
  logic [OW-1:0] t;
  logic          h;

  // S2 may load when empty or when its beat leaves; S1 likewise relative to S2.
  assign adv2       = !s2_valid || s.out_ready;
  assign adv1       = !s1_valid || adv2;
  assign s.in_ready = adv1;

  assign s.out_valid = s2_valid;
  assign s.r         = r_reg;
  assign s.g         = g_reg;
  assign s.b         = b_reg;
  assign s.out_last  = last_reg;

  // Colour arithmetic on the S1 beat; the top OW bits of each quantity are used.
  assign sum = {1'b0, s1_x_reg} + {1'b0, s1_y_reg};
  assign d   = (s1_x_reg > s1_y_reg) ? (s1_x_reg - s1_y_reg) : (s1_y_reg - s1_x_reg);
  assign avg = sum[W -: OW];
  assign dv  = d[W-1 -: OW];
  assign xt  = s1_x_reg[W-1 -: OW];
  assign yt  = s1_y_reg[W-1 -: OW];
  assign h   = avg[OW-1];
  assign t   = {avg[OW-2:0], 1'b0};

  // Low-order bits dropped by the truncations above are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{sum, d, s1_x_reg, s1_y_reg};

  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    case (s1_mode_reg)
      2'd0: begin
        r_next = xt;
        g_next = yt;
        b_next = ~avg;
      end
      2'd1: begin
        r_next = avg;
        g_next = avg;
        b_next = avg;
      end
      2'd2: begin
        // Sign of x - y selects the channel; equal coordinates give black.
        if (s1_x_reg > s1_y_reg) begin
          r_next = dv;
        end else if (s1_y_reg > s1_x_reg) begin
          b_next = dv;
        end
      end
      default: begin
        // Heat ramp: lower half blue->green, upper half green->red.
        if (!h) begin
          g_next = t;
          b_next = ~t;
        end else begin
          r_next = t;
          g_next = ~t;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_x_reg    <= '0;
      s1_y_reg    <= '0;
      s1_mode_reg <= '0;
      s1_last_reg <= 1'b0;
      r_reg       <= '0;
      g_reg       <= '0;
      b_reg       <= '0;
      last_reg    <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= s.in_valid;
      end
      // Data registers only load with a real beat so idle stages stay quiet.
      if (adv1 && s.in_valid) begin
        s1_x_reg    <= s.x;
        s1_y_reg    <= s.y;
        s1_mode_reg <= s.mode;
        s1_last_reg <= s.in_last;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
      end
      if (adv2 && s1_valid) begin
        r_reg    <= r_next;
        g_reg    <= g_next;
        b_reg    <= b_next;
        last_reg <= s1_last_reg;
      end
    end
  end

endmodule

// File: doc/color_map2d_stream.md
COLOR_MAP2D_STREAM -- requirements
Module: color_map2d_stream

Interface
REQ-001 SHALL have parameter W, default 8: width of each input coordinate x, y; legal W >= OW.
REQ-002 SHALL have parameter OW, default 8: width of each output colour channel; legal OW >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  the input beat is valid.
REQ-006 SHALL have port in_ready  output  1  the block accepts a beat this cycle.
REQ-007 SHALL have port x  input  W  first coordinate.
REQ-008 SHALL have port y  input  W  second coordinate.
REQ-009 SHALL have port mode  input  2  colour map for this beat, sampled with the beat.
REQ-010 SHALL have port in_last  input  1  end-of-line marker, carried with the beat.
REQ-011 SHALL have port out_valid  output  1  r/g/b/out_last are valid.
REQ-012 SHALL have port out_ready  input  1  the downstream consumer accepts the output.
REQ-013 SHALL have ports r, g, b  output  OW each  colour channels.
REQ-014 SHALL have port out_last  output  1  in_last of the same beat, delayed.

Function
REQ-015 SHALL transfer an input beat only when in_valid && in_ready, and an output beat only when out_valid && out_ready.
REQ-016 SHALL implement a 2-stage pipeline: S1 registers x, y, mode and last; S2 registers r, g, b and last; each stage has its own valid bit.
REQ-017 SHALL define adv2 = !s2_valid || out_ready, adv1 = !s1_valid || adv2, and in_ready = adv1 (combinational, with no dependence on in_valid).
REQ-018 SHALL have a latency of exactly 2 cycles from the accepting edge to out_valid when out_ready is held at 1, and sustain 1 beat/cycle.
REQ-019 SHALL hold r, g, b and out_last stable while out_valid && !out_ready; with out_ready low, it SHALL hold at most 2 beats.
REQ-020 SHALL define sum = x + y (W+1 bits, no overflow) and avg = sum[W -: OW].
REQ-021 SHALL define d = |x - y| (W bits), dv = d[W-1 -: OW], and xt = x[W-1 -: OW], yt = y[W-1 -: OW].
REQ-022 SHALL implement mode 0 (legacy): r = xt, g = yt, b = ~avg.
REQ-023 SHALL implement mode 1 (gray): r = g = b = avg.
REQ-024 SHALL implement mode 2 (difference): if x > y, r = dv, g = 0, b = 0; if y > x, r = 0, g = 0, b = dv; if x == y, all channels = 0.
REQ-025 SHALL implement mode 3 (heat), with h = avg[OW-1] and t = {avg[OW-2:0], 1'b0}: if h = 0, r = 0, g = t, b = ~t; if h = 1, r = t, g = ~t, b = 0.
REQ-026 SHALL compute each beat's colour from that beat's own sampled mode; a mode change between consecutive beats SHALL take effect with no bubble.
REQ-027 SHALL emit beats in the order they were accepted, with no loss or duplication under any out_ready pattern.
REQ-028 SHALL leave stage data registers unchanged when a stage's valid bit is 0 (no toggling requirement on data).

Reset
REQ-029 SHALL, while rst is high, clear s1_valid, s2_valid, out_valid, r, g, b and out_last to 0 immediately, without waiting for a clk edge.
REQ-030 SHALL discard in-flight beats when rst is asserted mid-operation; the first beat accepted after deassertion SHALL appear 2 cycles later.
REQ-031 SHALL drive in_ready to 1 during reset, with no beat accepted while rst is high.

Verification (W = OW = 8)
REQ-032 Bench SHALL check mode 0, x = 200, y = 100, out_ready = 1 -> 2 cycles later r = 200, g = 100, b = 105.
REQ-033 Bench SHALL check mode 1, x = 10, y = 21 -> r = g = b = 15; and mode 2, x = 50, y = 200 -> r = 0, g = 0, b = 150.
REQ-034 Bench SHALL check mode 3, x = y = 192 -> r = 128, g = 127, b = 0; and x = y = 32 -> r = 0, g = 64, b = 191.
REQ-035 Bench SHALL check out_ready = 0 with beats A, B, C offered back-to-back -> exactly A and B accepted and in_ready = 0 while C is held; then out_ready = 1 -> A, B, C emitted in order, each with its matching in_last.
REQ-036 Bench SHALL check rst pulsed with both stages full -> out_valid = 0 within the same cycle, and no stale beat after release.
REQ-037 Bench SHALL check a 1000-beat random stream with random modes and random in_valid/out_ready against a reference model -> bit-exact output with zero drops.
